// File: rtl/icache_pkg.sv
// Shared constants, state encoding and address helpers for the instruction cache.
package icache_pkg;

  localparam int ICACHE_SIZE = 256;
  localparam int IDX_W       = 8;
  localparam int TAG_W       = 22;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } icache_state_t;

  // Line index: address bits [9:2].
  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return addr[9:2];
  endfunction

  // Tag: address bits [31:10].
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:10];
  endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped, 256-line x 1-word instruction cache with a single outstanding
// miss to the memory controller. Hits are reported combinationally, including
// while a miss is pending. A clr abandons the pending miss without touching
// the array.
module icache
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rd_ena,
  input  logic [31:0] pc_in,
  input  logic        clr,
  output logic        instr_rdy,
  output logic [31:0] instr_out,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data
);

  logic [31:0]      data_mem [ICACHE_SIZE];
  logic [TAG_W-1:0] tag_mem  [ICACHE_SIZE];
  logic [ICACHE_SIZE-1:0] valid;

  icache_state_t state, next_state;

  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] fill_idx;
  logic             hit;
  logic             start_miss;
  logic             fill_en;

  assign pc_idx   = addr_idx(pc_in);
  assign fill_idx = addr_idx(mc_addr);

  // Hit lookup: valid line whose stored tag matches the fetch address.
  always_comb begin
    hit       = rd_ena && valid[pc_idx] && (tag_mem[pc_idx] == addr_tag(pc_in));
    instr_rdy = hit;
    instr_out = hit ? data_mem[pc_idx] : 32'h0;
  end

  // State register; rdy low freezes the FSM.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else if (rdy)
      state <= next_state;
  end

  // Next state: a miss moves to WAIT, fill completion or clr returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (rd_ena && !hit && !clr) next_state = WAIT;
      WAIT: if (clr || mc_done)         next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: when to latch a miss address and when to write a fill.
  always_comb begin
    start_miss = 1'b0;
    fill_en    = 1'b0;
    case (state)
      IDLE: start_miss = rdy && rd_ena && !hit && !clr;
      WAIT: fill_en    = rdy && mc_done && !clr;
      default: ;
    endcase
  end

  // The request line is simply "a miss is outstanding"; it is registered state.
  assign mc_req = (state == WAIT);

  // Miss address register, held constant for the whole of WAIT.
  always_ff @(posedge clk) begin
    if (rst)
      mc_addr <= 32'h0;
    else if (start_miss)
      mc_addr <= {pc_in[31:2], 2'b00};
  end

  // Valid bits: cleared on reset, set by a completed fill.
  always_ff @(posedge clk) begin
    if (rst)
      valid <= '0;
    else if (fill_en)
      valid[fill_idx] <= 1'b1;
  end

  // Tag and data arrays are not reset; a fill overwrites the indexed line.
  always_ff @(posedge clk) begin
    if (!rst && fill_en) begin
      data_mem[fill_idx] <= mc_data;
      tag_mem[fill_idx]  <= addr_tag(mc_addr);
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, conflict eviction,
// rollback, hit-under-miss, stall and reset during a miss.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rd_ena;
  logic [31:0] pc_in;
  logic        clr;
  logic        instr_rdy;
  logic [31:0] instr_out;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;

  int checkCount;
  int errorCount;

  icache dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .rd_ena    (rd_ena),
    .pc_in     (pc_in),
    .clr       (clr),
    .instr_rdy (instr_rdy),
    .instr_out (instr_out),
    .mc_req    (mc_req),
    .mc_addr   (mc_addr),
    .mc_done   (mc_done),
    .mc_data   (mc_data)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Present a fetch address and check the combinational hit result.
  task automatic probe(input string tag, input logic [31:0] addr, input logic expHit,
                       input logic [31:0] expData);
    rd_ena = 1'b1;
    pc_in  = addr;
    #1;
    checkOutput({tag, "_rdy"}, {31'h0, instr_rdy}, {31'h0, expHit});
    checkOutput({tag, "_out"}, instr_out, expData);
  endtask

  // Complete the pending miss with one mc_done pulse.
  task automatic fill(input logic [31:0] data);
    rd_ena  = 1'b0;
    mc_done = 1'b1;
    mc_data = data;
    applyStimulus();
    mc_done = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1; rdy = 1'b1; rd_ena = 1'b0; pc_in = 32'h0;
    clr = 1'b0; mc_done = 1'b0; mc_data = 32'h0;
    #1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;

    // Reset state.
    checkOutput("rst_req",  {31'h0, mc_req}, 32'h0);
    checkOutput("rst_addr", mc_addr, 32'h0);
    probe("rst_probe", 32'h4, 1'b0, 32'h0);

    // Cold miss on 0x4, fill three cycles later.
    applyStimulus();
    checkOutput("cold_req",  {31'h0, mc_req}, 32'h1);
    checkOutput("cold_addr", mc_addr, 32'h4);
    rd_ena = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("cold_hold", {31'h0, mc_req}, 32'h1);
    fill(32'h0000_0093);
    checkOutput("cold_req_drop", {31'h0, mc_req}, 32'h0);
    probe("cold_hit", 32'h4, 1'b1, 32'h0000_0093);
    rd_ena = 1'b0;
    #1;
    checkOutput("no_rdena", {31'h0, instr_rdy}, 32'h0);

    // Conflict: 0x404 shares index with 0x4 and evicts it.
    probe("conf_miss", 32'h404, 1'b0, 32'h0);
    applyStimulus();
    checkOutput("conf_req",  {31'h0, mc_req}, 32'h1);
    checkOutput("conf_addr", mc_addr, 32'h404);
    fill(32'h0000_AAAA);
    probe("conf_evict", 32'h4,   1'b0, 32'h0);
    probe("conf_hit",   32'h404, 1'b1, 32'h0000_AAAA);
    rd_ena = 1'b0;

    // Cache 0x8.
    probe("w8_miss", 32'h8, 1'b0, 32'h0);
    applyStimulus();
    fill(32'h0000_8888);
    probe("w8_hit", 32'h8, 1'b1, 32'h0000_8888);

    // Hit-under-miss while 0x200 is outstanding.
    probe("hum_miss", 32'h200, 1'b0, 32'h0);
    applyStimulus();
    checkOutput("hum_addr", mc_addr, 32'h200);
    probe("hum_hit8", 32'h8, 1'b1, 32'h0000_8888);
    applyStimulus();
    checkOutput("hum_addr_held", mc_addr, 32'h200);
    checkOutput("hum_req_held",  {31'h0, mc_req}, 32'h1);
    probe("hum_hit404", 32'h404, 1'b1, 32'h0000_AAAA);
    probe("hum_pending", 32'h200, 1'b0, 32'h0);
    fill(32'h0000_2222);
    probe("hum_filled", 32'h200, 1'b1, 32'h0000_2222);
    rd_ena = 1'b0;

    // Rollback: clr coincident with mc_done drops the fill.
    probe("rb_miss", 32'h100, 1'b0, 32'h0);
    applyStimulus();
    checkOutput("rb_req", {31'h0, mc_req}, 32'h1);
    rd_ena = 1'b0; clr = 1'b1; mc_done = 1'b1; mc_data = 32'hDEAD_BEEF;
    applyStimulus();
    clr = 1'b0; mc_done = 1'b0;
    checkOutput("rb_req_drop", {31'h0, mc_req}, 32'h0);
    probe("rb_still_miss", 32'h100, 1'b0, 32'h0);

    // clr in IDLE blocks a new miss; hits still reported.
    clr = 1'b1;
    probe("clr_idle_hit", 32'h8, 1'b1, 32'h0000_8888);
    pc_in = 32'h300;
    applyStimulus();
    checkOutput("clr_idle_req", {31'h0, mc_req}, 32'h0);
    clr = 1'b0;
    rd_ena = 1'b0;

    // mc_done in IDLE is ignored.
    mc_done = 1'b1; mc_data = 32'h5555_5555;
    applyStimulus();
    mc_done = 1'b0;
    checkOutput("idle_done_req", {31'h0, mc_req}, 32'h0);
    probe("idle_done_miss", 32'h100, 1'b0, 32'h0);

    // Stall: miss on 0x100, rdy low for four cycles with an mc_done pulse.
    applyStimulus();
    checkOutput("stall_addr", mc_addr, 32'h100);
    rdy = 1'b0;
    pc_in = 32'h500;
    for (int i = 0; i < 4; i++) begin
      mc_done = (i == 1);
      mc_data = 32'h1111_1111;
      applyStimulus();
      checkOutput("stall_req",  {31'h0, mc_req}, 32'h1);
      checkOutput("stall_addr_held", mc_addr, 32'h100);
    end
    mc_done = 1'b0;
    probe("stall_nofill", 32'h100, 1'b0, 32'h0);
    rdy = 1'b1;
    rd_ena = 1'b0;
    applyStimulus();
    checkOutput("stall_req_after", {31'h0, mc_req}, 32'h1);
    fill(32'h1111_1111);
    checkOutput("stall_req_drop", {31'h0, mc_req}, 32'h0);
    probe("stall_hit", 32'h100, 1'b1, 32'h1111_1111);

    // Reset during a miss drops it and invalidates everything.
    probe("rm_miss", 32'h600, 1'b0, 32'h0);
    applyStimulus();
    checkOutput("rm_req", {31'h0, mc_req}, 32'h1);
    rd_ena = 1'b0;
    rst = 1'b1; mc_done = 1'b1; mc_data = 32'h6666_6666;
    applyStimulus();
    rst = 1'b0; mc_done = 1'b0;
    checkOutput("rm_req_drop", {31'h0, mc_req}, 32'h0);
    checkOutput("rm_addr",     mc_addr, 32'h0);
    probe("rm_4",   32'h4,   1'b0, 32'h0);
    probe("rm_404", 32'h404, 1'b0, 32'h0);
    probe("rm_8",   32'h8,   1'b0, 32'h0);
    probe("rm_100", 32'h100, 1'b0, 32'h0);
    probe("rm_600", 32'h600, 1'b0, 32'h0);
    rd_ena = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
